slow_clk_monitor: RTL and testbench
===================================

Name: slow_clk_monitor

Overview:
- Receiving end of the divided slow clock produced by the team's clock dividers, e.g. the 4 s toggle output.
- Samples the slow square wave in the fast `clk` domain and emits one-cycle rise/fall strobes.
- Measures the rise-to-rise period in `clk` cycles and reports lock or timeout status.
- Sits between a divider output and consumers (FSMs, display logic) that need clean single-cycle ticks plus a health indication.

Parameters:
- EXPECT_PERIOD, 400_000_002, nominal `clk` cycles between rising edges of `clk_in`.
- TOL, 16, allowed absolute deviation of a measured period from EXPECT_PERIOD, in cycles.
- TIMEOUT, 800_000_004, `clk` cycles without a rise before status goes LOST.

Ports:
- clk  in  1  fast system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- clk_in  in  1  slow square wave being monitored; may be asynchronous to `clk`.
- rise  out  1  one-cycle strobe per detected rising edge.
- fall  out  1  one-cycle strobe per detected falling edge.
- period  out  32  last measured rise-to-rise period in `clk` cycles.
- period_valid  out  1  one-cycle strobe when `period` updates.
- locked  out  1  high while in LOCKED.
- timeout  out  1  high while in LOST.
- edge_cnt  out  16  count of rise strobes since reset; wraps 0xFFFF to 0.

Behaviour:
- Reset (rst high at posedge):
  - Sync stages, prev register, cnt, all outputs cleared to 0; state = IDLE.
  - A `clk_in` already high at reset release therefore yields one rise strobe.
- Input path:
  - N sync stages; N=1 by default, N=3 with the optional feature.
  - Prev register p <= last stage each cycle.
  - rise <= last & ~p; fall <= ~last & p. Both are registered.
- Latency from first posedge that samples the new `clk_in` level to the strobe being high:
  - 2 cycles with N=1.
  - 4 cycles with N=3.
- Cycle counter cnt (32-bit):
  - On the posedge that sets rise: cnt <= 0.
  - Otherwise cnt <= cnt+1, saturating at 0xFFFF_FFFF.
- Period capture, on the posedge that sets rise, when state is ACQ or LOCKED:
  - period <= cnt+1; period_valid <= 1 for one cycle.
  - Consecutive rises P cycles apart report period = P.
  - No capture in IDLE or LOST; period holds its value.
- In-tolerance test: |(cnt+1) − EXPECT_PERIOD| <= TOL, using unsigned compare of the larger minus the smaller. No wrap.
- State machine (IDLE, ACQ, LOCKED, LOST), where "rise event" = the posedge setting rise:
  - IDLE: rise event → ACQ. cnt == TIMEOUT-1 without rise event → LOST.
  - ACQ: rise event and in tolerance → LOCKED. Rise event out of tolerance → stay ACQ. Timeout → LOST.
  - LOCKED: rise event in tolerance → stay. Rise event out of tolerance → ACQ, locked drops the next cycle. Timeout → LOST.
  - LOST: rise event → ACQ, no period_valid on that event.
- Simultaneous events: a rise event on the same posedge as the timeout condition counts as a rise; no LOST.
- Outputs: locked = (state==LOCKED), timeout = (state==LOST), both registered with the state.
- edge_cnt increments on every rise event in all states.
- fall never affects state or cnt.
- rst asserted mid-measurement: everything returns to reset values next cycle. The partial period is discarded.

Optional Feature:
- Macro SLOW_CLK_MON_SYNC3_EN.
- Defined: three flip-flop synchronizer (N=3), strobe latency 4 cycles. Required when `clk_in` comes from another clock domain or a pin.
- Undefined: single sample stage (N=1), latency 2 cycles. Intended for `clk_in` generated from the same `clk`.
- Period values are identical in both builds, because the latency offset cancels.

Test Plan (EXPECT_PERIOD=20, TOL=2, TIMEOUT=50, macro undefined unless noted):
- Reset, then square wave period 20 (high 10, low 10), start low:
  - First rise strobe 2 cycles after the first high sample.
  - Second rise: period=20, period_valid pulse, locked=1 one cycle later.
  - fall strobe 10 cycles after each rise.
  - edge_cnt increments 1, 2, 3…
- Locked, then one period of 25:
  - period=25, state ACQ, locked=0.
  - Next period 21 → locked=1.
  - Period 22 (boundary) keeps lock; 23 drops it.
- Locked, then `clk_in` held low:
  - timeout=1 exactly 50 cycles after the last rise event.
  - Next rise: state ACQ, no period_valid.
  - Following 20-cycle period → locked=1.
- Rise event coincident with cnt==49: state does not go LOST; period=50 is captured; state ACQ.
- `clk_in` high at reset release: one rise strobe 2 cycles after release, edge_cnt=1.
- rst pulsed mid-period while locked: all outputs 0 next cycle, then reacquires.
- With SLOW_CLK_MON_SYNC3_EN: rise latency 4 cycles; periods still report 20.

Source files
------------

// File: rtl/slow_clk_monitor.sv
// slow_clk_monitor: edge strobes, period measurement and lock status
// for a slow divided clock. Build macro: SLOW_CLK_MON_SYNC3_EN.
module slow_clk_monitor #(
  parameter logic [31:0] EXPECT_PERIOD = 32'd400_000_002,
  parameter logic [31:0] TOL           = 32'd16,
  parameter logic [31:0] TIMEOUT       = 32'd800_000_004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_in,
  output logic        rise,
  output logic        fall,
  output logic [31:0] period,
  output logic        period_valid,
  output logic        locked,
  output logic        timeout,
  output logic [15:0] edge_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    LOCKED,
    LOST
  } state_t;

  state_t      state;
  state_t      state_n;
  logic        last;
  logic        p;
  logic        rise_ev;
  logic        fall_ev;
  logic [31:0] cnt;
  logic [32:0] meas;
  logic [32:0] expv;
  logic [32:0] diff;
  logic        in_tol;
  logic        tmo_hit;
  logic        capture;

`ifdef SLOW_CLK_MON_SYNC3_EN
  logic [2:0] sync;

  // three-stage synchronizer for an asynchronous clk_in
  always_ff @(posedge clk) begin
    if (rst) sync <= '0;
    else     sync <= {sync[1:0], clk_in};
  end

  assign last = sync[2];
`else
  logic sync;

  // single sample stage for a clk_in generated from clk
  always_ff @(posedge clk) begin
    if (rst) sync <= 1'b0;
    else     sync <= clk_in;
  end

  assign last = sync;
`endif

  assign rise_ev = last & ~p;
  assign fall_ev = ~last & p;

  // measured period; the extra bit keeps the tolerance test wrap-free
  assign meas = {1'b0, cnt} + 33'd1;
  assign expv = {1'b0, EXPECT_PERIOD};
  assign diff = (meas >= expv) ? (meas - expv) : (expv - meas);

  assign in_tol  = (diff <= {1'b0, TOL});
  assign tmo_hit = (cnt == (TIMEOUT - 32'd1));
  assign capture = rise_ev & ((state == ACQ) | (state == LOCKED));

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // next-state logic; a rise on the timeout cycle wins over LOST
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (rise_ev)      state_n = ACQ;
        else if (tmo_hit) state_n = LOST;
      end
      ACQ, LOCKED: begin
        if (rise_ev)      state_n = in_tol ? LOCKED : ACQ;
        else if (tmo_hit) state_n = LOST;
      end
      LOST: begin
        if (rise_ev)      state_n = ACQ;
      end
      default: state_n = IDLE;
    endcase
  end

  // edge detect, cycle counter, period capture and edge counter
  always_ff @(posedge clk) begin
    if (rst) begin
      p            <= 1'b0;
      rise         <= 1'b0;
      fall         <= 1'b0;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      edge_cnt     <= '0;
    end else begin
      p            <= last;
      rise         <= rise_ev;
      fall         <= fall_ev;
      period_valid <= capture;
      if (rise_ev)
        cnt <= '0;
      else if (cnt != 32'hFFFF_FFFF)
        cnt <= cnt + 32'd1;
      if (capture)
        period <= meas[32] ? 32'hFFFF_FFFF : meas[31:0];
      if (rise_ev)
        edge_cnt <= edge_cnt + 16'd1;
    end
  end

  assign locked  = (state == LOCKED);
  assign timeout = (state == LOST);

endmodule

// File: tb/tb_slow_clk_monitor.sv
// tb_slow_clk_monitor: directed bench with a period scoreboard
// for slow_clk_monitor (EXPECT_PERIOD=20, TOL=2, TIMEOUT=50).
module tb_slow_clk_monitor;

`ifdef SLOW_CLK_MON_SYNC3_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic        clk;
  logic        rst;
  logic        clk_in;
  logic        rise;
  logic        fall;
  logic [31:0] period;
  logic        period_valid;
  logic        locked;
  logic        timeout;
  logic [15:0] edge_cnt;

  int          n_cmp;
  int          n_bad;
  int          exp_edge;
  int unsigned exp_q[$];

  slow_clk_monitor #(
    .EXPECT_PERIOD(32'd20),
    .TOL          (32'd2),
    .TIMEOUT      (32'd50)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clk_in      (clk_in),
    .rise        (rise),
    .fall        (fall),
    .period      (period),
    .period_valid(period_valid),
    .locked      (locked),
    .timeout     (timeout),
    .edge_cnt    (edge_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // one square-wave period: hi cycles high then lo cycles low
  task automatic wave(int hi, int lo, bit cap, int per, bit lk);
    if (cap) exp_q.push_back(per);
    clk_in = 1'b1;
    step(LAT - 1);
    chk("rise_early", 32'(rise), 32'd0);
    step(1);
    exp_edge++;
    chk("rise", 32'(rise), 32'd1);
    chk("edge_cnt", 32'(edge_cnt), 32'(exp_edge));
    chk("locked", 32'(locked), 32'(lk));
    chk("timeout_at_rise", 32'(timeout), 32'd0);
    step(1);
    chk("rise_width", 32'(rise), 32'd0);
    step(hi - LAT - 1);
    clk_in = 1'b0;
    step(LAT);
    chk("fall", 32'(fall), 32'd1);
    step(lo - LAT);
  endtask

  // scoreboard: every period_valid pulse consumes one expected period
  always @(negedge clk) begin
    if (period_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $error("FAIL period_spurious: observed %0d expected none",
               period);
      end else begin
        chk("period", period, exp_q.pop_front());
      end
    end
  end

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    exp_edge = 0;
    rst      = 1'b1;
    clk_in   = 1'b0;
    step(3);
    chk("rst_rise", 32'(rise), 32'd0);
    chk("rst_period", period, 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_edge", 32'(edge_cnt), 32'd0);
    rst = 1'b0;
    step(2);

    // acquire and lock on a clean 20-cycle wave
    wave(10, 10, 1'b0, 0, 1'b0);
    wave(10, 10, 1'b1, 20, 1'b1);
    wave(10, 10, 1'b1, 20, 1'b1);
    // 25 drops lock, 21 relocks, 22 holds, 23 drops
    wave(10, 15, 1'b1, 20, 1'b1);
    wave(10, 11, 1'b1, 25, 1'b0);
    wave(10, 12, 1'b1, 21, 1'b1);
    wave(10, 13, 1'b1, 22, 1'b1);
    wave(10, 10, 1'b1, 23, 1'b0);
    wave(10, 10, 1'b1, 20, 1'b1);

    // hold low: LOST exactly 50 cycles after the last rise
    step(49 - (20 - LAT));
    chk("pre_timeout", 32'(timeout), 32'd0);
    chk("pre_timeout_lock", 32'(locked), 32'd1);
    step(1);
    chk("timeout", 32'(timeout), 32'd1);
    chk("timeout_lock", 32'(locked), 32'd0);
    chk("timeout_period_hold", period, 32'd20);
    wave(10, 10, 1'b0, 0, 1'b0);
    wave(10, 10, 1'b1, 20, 1'b1);

    // rise coincident with cnt==49 wins over timeout
    wave(10, 40, 1'b1, 20, 1'b1);
    wave(10, 10, 1'b1, 50, 1'b0);
    wave(10, 10, 1'b1, 20, 1'b1);

    // reset mid-period with clk_in high at release
    step(5);
    rst    = 1'b1;
    clk_in = 1'b1;
    step(1);
    exp_edge = 0;
    chk("mid_rst_period", period, 32'd0);
    chk("mid_rst_locked", 32'(locked), 32'd0);
    chk("mid_rst_edge", 32'(edge_cnt), 32'd0);
    chk("mid_rst_pv", 32'(period_valid), 32'd0);
    rst = 1'b0;
    step(LAT - 1);
    chk("rel_rise_early", 32'(rise), 32'd0);
    step(1);
    exp_edge++;
    chk("rel_rise", 32'(rise), 32'd1);
    chk("rel_edge", 32'(edge_cnt), 32'd1);
    clk_in = 1'b0;
    step(20 - LAT);
    wave(10, 10, 1'b1, 20, 1'b1);
    step(2);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
